// File: rtl/multicycle_control_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_if : IR/flag/memory-handshake inputs and control      |
// | outputs of the multi-cycle MIPS sequencer.            Rev 1.0            |
// +--------------------------------------------------------------------------+
interface multicycle_control_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      instr;
   logic             zero;
   logic             mem_ready;

   logic             PCWrite;
   logic             PCWriteCond;
   logic             BranchNe;
   logic             IorD;
   logic             MemRead;
   logic             MemWrite;
   logic             IRWrite;
   logic             MemToReg;
   logic             RegDst;
   logic             RegWrite;
   logic             Link;
   logic             Lui;
   logic             ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [2:0]       ALUop;
   logic [1:0]       PCSource;
   logic             halted;
   logic             bus_error;
   logic             illegal;
   logic [3:0]       state;
   logic [CNT_W-1:0] retired;

   modport master (
      input  instr, zero, mem_ready,
      output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
             MemToReg, RegDst, RegWrite, Link, Lui, ALUSrcA, ALUSrcB, ALUop,
             PCSource, halted, bus_error, illegal, state, retired
   );

   modport slave (
      output instr, zero, mem_ready,
      input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
             MemToReg, RegDst, RegWrite, Link, Lui, ALUSrcA, ALUSrcB, ALUop,
             PCSource, halted, bus_error, illegal, state, retired
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control : Moore sequencer for the multi-cycle MIPS datapath   |
// | with memory-wait watchdog, halt state and retired counter.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module multicycle_control #(
   parameter int MEM_WAIT_MAX = 255,
   parameter int CNT_W        = 32
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   multicycle_control_if.master  bus
);
   localparam int c_WD_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

   localparam logic [5:0] c_OP_SPECIAL = 6'h00;
   localparam logic [5:0] c_OP_J       = 6'h02;
   localparam logic [5:0] c_OP_JAL     = 6'h03;
   localparam logic [5:0] c_OP_BEQ     = 6'h04;
   localparam logic [5:0] c_OP_BNE     = 6'h05;
   localparam logic [5:0] c_OP_ADDI    = 6'h08;
   localparam logic [5:0] c_OP_ADDIU   = 6'h09;
   localparam logic [5:0] c_OP_SLTIU   = 6'h0B;
   localparam logic [5:0] c_OP_ORI     = 6'h0D;
   localparam logic [5:0] c_OP_LUI     = 6'h0F;
   localparam logic [5:0] c_OP_LW      = 6'h23;
   localparam logic [5:0] c_OP_SW      = 6'h2B;

   localparam logic [5:0] c_FN_JR      = 6'h08;
   localparam logic [5:0] c_FN_SYSCALL = 6'h0C;
   localparam logic [5:0] c_FN_ADD     = 6'h20;
   localparam logic [5:0] c_FN_SUB     = 6'h22;
   localparam logic [5:0] c_FN_AND     = 6'h24;
   localparam logic [5:0] c_FN_OR      = 6'h25;
   localparam logic [5:0] c_FN_SLT     = 6'h2A;

   localparam logic [2:0] c_ALU_ADD = 3'b010;
   localparam logic [2:0] c_ALU_SUB = 3'b110;
   localparam logic [2:0] c_ALU_AND = 3'b000;
   localparam logic [2:0] c_ALU_OR  = 3'b001;
   localparam logic [2:0] c_ALU_SLT = 3'b111;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_RTWB  = 4'd7,
      S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       link;
      logic       lui;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       halted;
   } ctl_t;

   state_t             r_state;
   ctl_t               r_ctl;
   logic [c_WD_W-1:0]  r_wd;
   logic               r_bus_error;
   logic               r_illegal;
   logic [CNT_W-1:0]   r_retired;

   state_t             w_next;
   ctl_t               w_ctl;
   logic               w_illegal_dec;
   logic               w_waiting;
   logic               w_wd_limit;
   logic               w_retire;
   logic               w_fetch_ack;
   logic [5:0]         w_op;
   logic [5:0]         w_fn;
   logic               w_is_jr;
   logic [2:0]         w_rt_aluop;
   logic [2:0]         w_i_aluop;
   logic               w_unused;

   assign w_op     = bus.instr[31:26];
   assign w_fn     = bus.instr[5:0];
   assign w_is_jr  = (w_op == c_OP_SPECIAL) && (w_fn == c_FN_JR);
   // zero is consumed by the datapath's PC-write gate, not by the sequencer
   assign w_unused = ^{bus.zero, bus.instr[25:6]};

   assign w_waiting  = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                       && !bus.mem_ready;
   assign w_wd_limit = w_waiting && (r_wd == c_WD_W'(MEM_WAIT_MAX - 1));

   always_comb begin
      w_rt_aluop = c_ALU_ADD;
      case (w_fn)
         c_FN_SUB: w_rt_aluop = c_ALU_SUB;
         c_FN_AND: w_rt_aluop = c_ALU_AND;
         c_FN_OR:  w_rt_aluop = c_ALU_OR;
         c_FN_SLT: w_rt_aluop = c_ALU_SLT;
         default:  w_rt_aluop = c_ALU_ADD;
      endcase
      w_i_aluop = c_ALU_ADD;
      case (w_op)
         c_OP_ORI:   w_i_aluop = c_ALU_OR;
         c_OP_SLTIU: w_i_aluop = c_ALU_SLT;
         default:    w_i_aluop = c_ALU_ADD;
      endcase
   end

   always_comb begin
      w_next        = r_state;
      w_illegal_dec = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (bus.mem_ready)   w_next = S_DECODE;
            else if (w_wd_limit) w_next = S_HALT;
         end
         S_DECODE: begin
            case (w_op)
               c_OP_LW, c_OP_SW: w_next = S_MEMADR;
               c_OP_SPECIAL: begin
                  case (w_fn)
                     c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: w_next = S_RTEXEC;
                     c_FN_JR:      w_next = S_JUMP;
                     c_FN_SYSCALL: w_next = S_HALT;
                     default: begin
                        w_next        = S_FETCH;
                        w_illegal_dec = 1'b1;
                     end
                  endcase
               end
               c_OP_ADDI, c_OP_ADDIU, c_OP_ORI, c_OP_SLTIU, c_OP_LUI: w_next = S_IEXEC;
               c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
               c_OP_J, c_OP_JAL:   w_next = S_JUMP;
               default: begin
                  w_next        = S_FETCH;
                  w_illegal_dec = 1'b1;
               end
            endcase
         end
         S_MEMADR: w_next = (w_op == c_OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (bus.mem_ready)   w_next = S_MEMWB;
            else if (w_wd_limit) w_next = S_HALT;
         end
         S_MEMWB:  w_next = S_FETCH;
         S_MEMWR: begin
            if (bus.mem_ready)   w_next = S_FETCH;
            else if (w_wd_limit) w_next = S_HALT;
         end
         S_RTEXEC: w_next = S_RTWB;
         S_RTWB:   w_next = S_FETCH;
         S_IEXEC:  w_next = S_IWB;
         S_IWB:    w_next = S_FETCH;
         S_BRANCH: w_next = S_FETCH;
         S_JUMP:   w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   assign w_retire = ((w_next == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWR) || (r_state == S_RTWB) ||
                       (r_state == S_IWB)   || (r_state == S_BRANCH) || (r_state == S_JUMP)))
                     || ((r_state == S_DECODE) && (w_next == S_HALT));

   // Outputs are decoded from the next state so they appear registered in that state.
   always_comb begin
      w_ctl = '0;
      case (w_next)
         S_FETCH: begin
            w_ctl.mem_read  = 1'b1;
            w_ctl.alu_src_b = 2'b01;
            w_ctl.alu_op    = c_ALU_ADD;
         end
         S_DECODE: begin
            w_ctl.alu_src_b = 2'b11;
            w_ctl.alu_op    = c_ALU_ADD;
         end
         S_MEMADR: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_src_b = 2'b10;
            w_ctl.alu_op    = c_ALU_ADD;
         end
         S_MEMRD: begin
            w_ctl.mem_read = 1'b1;
            w_ctl.iord     = 1'b1;
         end
         S_MEMWB: begin
            w_ctl.reg_write  = 1'b1;
            w_ctl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            w_ctl.mem_write = 1'b1;
            w_ctl.iord      = 1'b1;
         end
         S_RTEXEC: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_op    = w_rt_aluop;
         end
         S_RTWB: begin
            w_ctl.reg_write = 1'b1;
            w_ctl.reg_dst   = 1'b1;
         end
         S_IEXEC: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_src_b = 2'b10;
            w_ctl.alu_op    = w_i_aluop;
            w_ctl.lui       = (w_op == c_OP_LUI);
         end
         S_IWB: begin
            w_ctl.reg_write = 1'b1;
            w_ctl.lui       = (w_op == c_OP_LUI);
         end
         S_BRANCH: begin
            w_ctl.alu_src_a     = 1'b1;
            w_ctl.alu_op        = c_ALU_SUB;
            w_ctl.pc_write_cond = 1'b1;
            w_ctl.pc_source     = 2'b01;
            w_ctl.branch_ne     = (w_op == c_OP_BNE);
         end
         S_JUMP: begin
            w_ctl.pc_write  = 1'b1;
            w_ctl.pc_source = w_is_jr ? 2'b11 : 2'b10;
            w_ctl.reg_write = (w_op == c_OP_JAL);
            w_ctl.link      = (w_op == c_OP_JAL);
         end
         S_HALT:  w_ctl.halted = 1'b1;
         default: w_ctl = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state           <= S_FETCH;
         r_ctl             <= '0;
         r_ctl.mem_read    <= 1'b1;
         r_ctl.alu_src_b   <= 2'b01;
         r_ctl.alu_op      <= c_ALU_ADD;
         r_wd              <= '0;
         r_bus_error       <= 1'b0;
         r_illegal         <= 1'b0;
         r_retired         <= '0;
      end else begin
         r_state     <= w_next;
         r_ctl       <= w_ctl;
         r_wd        <= (w_waiting && !w_wd_limit) ? r_wd + c_WD_W'(1) : '0;
         r_bus_error <= r_bus_error | w_wd_limit;
         r_illegal   <= w_illegal_dec;
         if (w_retire) r_retired <= r_retired + CNT_W'(1);
      end
   end

   // IR/PC load in FETCH follows mem_ready in the same cycle.
   assign w_fetch_ack     = (r_state == S_FETCH) && bus.mem_ready;
   assign bus.IRWrite     = w_fetch_ack;
   assign bus.PCWrite     = r_ctl.pc_write | w_fetch_ack;
   assign bus.PCWriteCond = r_ctl.pc_write_cond;
   assign bus.BranchNe    = r_ctl.branch_ne;
   assign bus.IorD        = r_ctl.iord;
   assign bus.MemRead     = r_ctl.mem_read;
   assign bus.MemWrite    = r_ctl.mem_write;
   assign bus.MemToReg    = r_ctl.mem_to_reg;
   assign bus.RegDst      = r_ctl.reg_dst;
   assign bus.RegWrite    = r_ctl.reg_write;
   assign bus.Link        = r_ctl.link;
   assign bus.Lui         = r_ctl.lui;
   assign bus.ALUSrcA     = r_ctl.alu_src_a;
   assign bus.ALUSrcB     = r_ctl.alu_src_b;
   assign bus.ALUop       = r_ctl.alu_op;
   assign bus.PCSource    = r_ctl.pc_source;
   assign bus.halted      = r_ctl.halted;
   assign bus.bus_error   = r_bus_error;
   assign bus.illegal     = r_illegal;
   assign bus.state       = r_state;
   assign bus.retired     = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_control : table-driven check of the multi-cycle sequencer. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_multicycle_control;
   localparam logic [22:0] c_PCW  = 23'd1 << 22;
   localparam logic [22:0] c_PCWC = 23'd1 << 21;
   localparam logic [22:0] c_BNE  = 23'd1 << 20;
   localparam logic [22:0] c_IORD = 23'd1 << 19;
   localparam logic [22:0] c_MRD  = 23'd1 << 18;
   localparam logic [22:0] c_MWR  = 23'd1 << 17;
   localparam logic [22:0] c_IRW  = 23'd1 << 16;
   localparam logic [22:0] c_M2R  = 23'd1 << 15;
   localparam logic [22:0] c_RDST = 23'd1 << 14;
   localparam logic [22:0] c_RWR  = 23'd1 << 13;
   localparam logic [22:0] c_LNK  = 23'd1 << 12;
   localparam logic [22:0] c_LUI  = 23'd1 << 11;
   localparam logic [22:0] c_SRCA = 23'd1 << 10;
   localparam logic [22:0] c_SB01 = 23'd1 << 8;
   localparam logic [22:0] c_SB10 = 23'd2 << 8;
   localparam logic [22:0] c_SB11 = 23'd3 << 8;
   localparam logic [22:0] c_OADD = 23'd2 << 5;
   localparam logic [22:0] c_OSUB = 23'd6 << 5;
   localparam logic [22:0] c_OAND = 23'd0;
   localparam logic [22:0] c_OOR  = 23'd1 << 5;
   localparam logic [22:0] c_OSLT = 23'd7 << 5;
   localparam logic [22:0] c_PS01 = 23'd1 << 3;
   localparam logic [22:0] c_PS10 = 23'd2 << 3;
   localparam logic [22:0] c_PS11 = 23'd3 << 3;
   localparam logic [22:0] c_HLT  = 23'd1 << 2;
   localparam logic [22:0] c_BERR = 23'd1 << 1;
   localparam logic [22:0] c_ILL  = 23'd1;

   localparam logic [22:0] c_F    = c_MRD | c_SB01 | c_OADD;
   localparam logic [22:0] c_FR   = c_F | c_IRW | c_PCW;
   localparam logic [22:0] c_D    = c_SB11 | c_OADD;
   localparam logic [22:0] c_MA   = c_SRCA | c_SB10 | c_OADD;
   localparam logic [22:0] c_MRDW = c_MRD | c_IORD;
   localparam logic [22:0] c_MWB  = c_RWR | c_M2R;
   localparam logic [22:0] c_MWRW = c_MWR | c_IORD;
   localparam logic [22:0] c_RTWB = c_RWR | c_RDST;
   localparam logic [22:0] c_IEX  = c_SRCA | c_SB10;
   localparam logic [22:0] c_BR   = c_SRCA | c_OSUB | c_PCWC | c_PS01;

   typedef struct {
      logic [31:0] instr;
      logic        mr;
      logic        z;
      logic [3:0]  st;
      logic [22:0] ctl;
      logic [31:0] ret;
   } vec_t;

   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_bad;
   vec_t vq[$];

   multicycle_control_if #(.CNT_W(32)) bus ();

   multicycle_control #(.MEM_WAIT_MAX(4), .CNT_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [22:0] act_ctl();
      return {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.IorD, bus.MemRead,
              bus.MemWrite, bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite,
              bus.Link, bus.Lui, bus.ALUSrcA, bus.ALUSrcB, bus.ALUop, bus.PCSource,
              bus.halted, bus.bus_error, bus.illegal};
   endfunction

   task automatic check(input string name, input logic [3:0] est,
                        input logic [22:0] ectl, input logic [31:0] eret);
      logic [22:0] a;
      a = act_ctl();
      n_vec++;
      if (bus.state !== est || a !== ectl || bus.retired !== eret) begin
         n_bad++;
         $display("FAIL %s: got state=%0d ctl=%06h retired=%0d, expected state=%0d ctl=%06h retired=%0d",
                  name, bus.state, a, bus.retired, est, ectl, eret);
      end
   endtask

   task automatic add(input logic [31:0] ins, input logic mr, input logic z,
                      input logic [3:0] st, input logic [22:0] ctl, input logic [31:0] ret);
      vec_t v;
      v.instr = ins; v.mr = mr; v.z = z; v.st = st; v.ctl = ctl; v.ret = ret;
      vq.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset_n = 1'b0;
      bus.instr = 32'h0;
      bus.mem_ready = 1'b0;
      bus.zero = 1'b0;

      // ADD: 0,1,6,7
      add(32'h00221820,1,0, 0,c_FR,0);  add(32'h00221820,1,0, 1,c_D,0);
      add(32'h00221820,1,0, 6,c_SRCA|c_OADD,0); add(32'h00221820,1,0, 7,c_RTWB,0);
      // SUB after two FETCH wait cycles
      add(32'h00221822,0,0, 0,c_F,1);   add(32'h00221822,0,0, 0,c_F,1);
      add(32'h00221822,1,0, 0,c_FR,1);  add(32'h00221822,1,0, 1,c_D,1);
      add(32'h00221822,1,0, 6,c_SRCA|c_OSUB,1); add(32'h00221822,1,0, 7,c_RTWB,1);
      // AND, OR, SLT
      add(32'h00221824,1,0, 0,c_FR,2);  add(32'h00221824,1,0, 1,c_D,2);
      add(32'h00221824,1,0, 6,c_SRCA|c_OAND,2); add(32'h00221824,1,0, 7,c_RTWB,2);
      add(32'h00221825,1,0, 0,c_FR,3);  add(32'h00221825,1,0, 1,c_D,3);
      add(32'h00221825,1,0, 6,c_SRCA|c_OOR,3);  add(32'h00221825,1,0, 7,c_RTWB,3);
      add(32'h0022182A,1,0, 0,c_FR,4);  add(32'h0022182A,1,0, 1,c_D,4);
      add(32'h0022182A,1,0, 6,c_SRCA|c_OSLT,4); add(32'h0022182A,1,0, 7,c_RTWB,4);
      // LW, mem_ready low 3 cycles in MEMRD; ready arrives as the watchdog would trip
      add(32'h8C220004,1,0, 0,c_FR,5);  add(32'h8C220004,1,0, 1,c_D,5);
      add(32'h8C220004,1,0, 2,c_MA,5);
      add(32'h8C220004,0,0, 3,c_MRDW,5); add(32'h8C220004,0,0, 3,c_MRDW,5);
      add(32'h8C220004,0,0, 3,c_MRDW,5); add(32'h8C220004,1,0, 3,c_MRDW,5);
      add(32'h8C220004,1,0, 4,c_MWB,5);
      // SW with one wait cycle
      add(32'hAC220004,1,0, 0,c_FR,6);  add(32'hAC220004,1,0, 1,c_D,6);
      add(32'hAC220004,1,0, 2,c_MA,6);
      add(32'hAC220004,0,0, 5,c_MWRW,6); add(32'hAC220004,1,0, 5,c_MWRW,6);
      // ADDI, ORI, SLTIU, LUI
      add(32'h20220005,1,0, 0,c_FR,7);  add(32'h20220005,1,0, 1,c_D,7);
      add(32'h20220005,1,0, 8,c_IEX|c_OADD,7); add(32'h20220005,1,0, 9,c_RWR,7);
      add(32'h34220005,1,0, 0,c_FR,8);  add(32'h34220005,1,0, 1,c_D,8);
      add(32'h34220005,1,0, 8,c_IEX|c_OOR,8);  add(32'h34220005,1,0, 9,c_RWR,8);
      add(32'h2C220005,1,0, 0,c_FR,9);  add(32'h2C220005,1,0, 1,c_D,9);
      add(32'h2C220005,1,0, 8,c_IEX|c_OSLT,9); add(32'h2C220005,1,0, 9,c_RWR,9);
      add(32'h3C021234,1,0, 0,c_FR,10); add(32'h3C021234,1,0, 1,c_D,10);
      add(32'h3C021234,1,0, 8,c_IEX|c_OADD|c_LUI,10); add(32'h3C021234,1,0, 9,c_RWR|c_LUI,10);
      // BNE (zero=0), BEQ (zero=1)
      add(32'h14220003,1,0, 0,c_FR,11); add(32'h14220003,1,0, 1,c_D,11);
      add(32'h14220003,1,0, 10,c_BR|c_BNE,11);
      add(32'h10220003,1,1, 0,c_FR,12); add(32'h10220003,1,1, 1,c_D,12);
      add(32'h10220003,1,1, 10,c_BR,12);
      // JAL, JR $31, J
      add(32'h0C000010,1,0, 0,c_FR,13); add(32'h0C000010,1,0, 1,c_D,13);
      add(32'h0C000010,1,0, 11,c_PCW|c_PS10|c_RWR|c_LNK,13);
      add(32'h03E00008,1,0, 0,c_FR,14); add(32'h03E00008,1,0, 1,c_D,14);
      add(32'h03E00008,1,0, 11,c_PCW|c_PS11,14);
      add(32'h08000010,1,0, 0,c_FR,15); add(32'h08000010,1,0, 1,c_D,15);
      add(32'h08000010,1,0, 11,c_PCW|c_PS10,15);
      // opcode 0x3F, then SPECIAL/ADDU: illegal pulses, retired unchanged
      add(32'hFC000000,1,0, 0,c_FR,16); add(32'hFC000000,1,0, 1,c_D,16);
      add(32'h00221821,1,0, 0,c_FR|c_ILL,16); add(32'h00221821,1,0, 1,c_D,16);
      // SYSCALL: halt, retired counted, stays halted
      add(32'h0000000C,1,0, 0,c_FR|c_ILL,16); add(32'h0000000C,1,0, 1,c_D,16);
      add(32'h0000000C,1,0, 12,c_HLT,17); add(32'h0000000C,0,0, 12,c_HLT,17);
      add(32'h0000000C,1,0, 12,c_HLT,17);

      @(negedge clk); #1;
      check("reset", 4'd0, c_F, 32'd0);
      reset_n = 1'b1;

      foreach (vq[i]) begin
         bus.instr     = vq[i].instr;
         bus.mem_ready = vq[i].mr;
         bus.zero      = vq[i].z;
         #1;
         check($sformatf("vec%0d", i), vq[i].st, vq[i].ctl, vq[i].ret);
         @(negedge clk);
      end

      // Watchdog: 4 FETCH cycles without mem_ready -> HALT with sticky bus_error
      reset_n = 1'b0;
      bus.mem_ready = 1'b0;
      bus.instr = 32'h0;
      #1;
      check("wd_reset", 4'd0, c_F, 32'd0);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("wd_wait%0d", k), 4'd0, c_F, 32'd0);
         @(negedge clk); #1;
      end
      check("wd_halt", 4'd12, c_HLT | c_BERR, 32'd0);
      bus.mem_ready = 1'b1;
      @(negedge clk); #1;
      check("wd_sticky", 4'd12, c_HLT | c_BERR, 32'd0);

      // Async reset in the middle of a MEMWR wait drops MemWrite at once
      bus.mem_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      check("rst_clear", 4'd0, c_F, 32'd0);
      reset_n = 1'b1;
      bus.instr = 32'hAC220004;
      bus.mem_ready = 1'b1;
      #1;
      check("sw_fetch", 4'd0, c_FR, 32'd0);
      @(negedge clk); #1;
      check("sw_decode", 4'd1, c_D, 32'd0);
      @(negedge clk); #1;
      check("sw_memadr", 4'd2, c_MA, 32'd0);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      check("sw_memwr", 4'd5, c_MWRW, 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst", 4'd0, c_F, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
